// File: rtl/fetch_ctrl.sv
// Instruction-fetch sequencer: MAR <- PC, PC+1, wait for memory, IR <- MDR.
// Define FETCH_TIMEOUT_EN to abort a stalled WAIT after TIMEOUT cycles.
module fetch_ctrl #(
    parameter int TIMEOUT = 15
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [15:0] PC,
    output logic        ldPC,
    output logic [1:0]  selPC,
    output logic [15:0] memAddr,
    output logic        memEN,
    input  logic [15:0] memData,
    input  logic        memR,
    output logic [15:0] IR,
    output logic        irValid,
    output logic        busy,
    output logic        fetchErr
);

    typedef enum logic [1:0] {
        IDLE,
        ADDR,
        WAIT,
        LOAD
    } state_t;

    state_t      state;
    logic [15:0] mar;
    logic [15:0] mdr;

    if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
        $error("fetch_ctrl: TIMEOUT out of range 1..255");
    end

    assign ldPC    = (state == ADDR);
    assign memEN   = (state == WAIT);
    assign busy    = (state != IDLE);
    assign memAddr = mar;
    assign selPC   = 2'b00;

`ifdef FETCH_TIMEOUT_EN
    localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

    logic [7:0] count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            mar      <= '0;
            mdr      <= '0;
            IR       <= '0;
            count    <= '0;
            irValid  <= 1'b0;
            fetchErr <= 1'b0;
        end else begin
            irValid  <= 1'b0;
            fetchErr <= 1'b0;
            unique case (state)
                IDLE: if (start) state <= ADDR;
                ADDR: begin
                    mar   <= PC;
                    count <= '0;
                    state <= WAIT;
                end
                WAIT: begin
                    // A late memR still wins over the abort.
                    if (memR) begin
                        mdr   <= memData;
                        state <= LOAD;
                    end else if (count == LAST) begin
                        fetchErr <= 1'b1;
                        state    <= IDLE;
                    end else begin
                        count <= count + 8'd1;
                    end
                end
                LOAD: begin
                    IR      <= mdr;
                    irValid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`else
    assign fetchErr = 1'b0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            mar     <= '0;
            mdr     <= '0;
            IR      <= '0;
            irValid <= 1'b0;
        end else begin
            irValid <= 1'b0;
            unique case (state)
                IDLE: if (start) state <= ADDR;
                ADDR: begin
                    mar   <= PC;
                    state <= WAIT;
                end
                WAIT: begin
                    if (memR) begin
                        mdr   <= memData;
                        state <= LOAD;
                    end
                end
                LOAD: begin
                    IR      <= mdr;
                    irValid <= 1'b1;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
`endif

endmodule
